trigger_readout_scheduler: RTL

- Consumes the trigger handler's T1 strobe, T1 block offset, matched L4 pattern and L4-new flags, and turns them into an ordered list of IRS block addresses to digitize.
- Computes each event's start block from the live write pointer, merges overlapping triggers into one event window, and holds back blocks until they are fully written.
- Queues block entries in a first-word-fall-through FIFO for the downstream readout/digitizer sequencer.

---
 rtl/trigger_readout_scheduler.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/trigger_readout_scheduler.sv
// trigger_readout_scheduler
// Turns T1 strobes and L4 flags into an ordered stream of IRS block
// addresses. Overlapping triggers are merged into one event window.
// Blocks that are still being written are held back. The entries are
// queued in a first-word-fall-through FIFO for the digitizer sequencer.

`ifndef SCAL_NUM_L4
`define SCAL_NUM_L4 4
`endif

module trigger_readout_scheduler #(
    parameter int NUM_L4          = `SCAL_NUM_L4,
    parameter int BLOCK_BITS      = 9,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int MAX_LAG         = 448
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  T1_i,
    input  logic [8:0]            T1_offset_i,
    input  logic [NUM_L4-1:0]     l4_matched_i,
    input  logic [NUM_L4-1:0]     l4_new_i,
    input  logic [BLOCK_BITS-1:0] wr_block_i,
    input  logic [7:0]            readout_len_i,
    output logic                  blk_valid_o,
    input  logic                  blk_ack_i,
    output logic [BLOCK_BITS-1:0] blk_addr_o,
    output logic                  blk_first_o,
    output logic                  blk_last_o,
    output logic                  blk_err_o,
    output logic [NUM_L4-1:0]     blk_pattern_o,
    output logic                  busy_o,
    output logic                  overflow_o,
    output logic [15:0]           event_count_o
);

    // ------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_ABORT  = 2'd2;

    localparam logic [BLOCK_BITS-1:0]    MAX_LAG_B = BLOCK_BITS'(MAX_LAG);
    localparam logic [BLOCK_BITS-1:0]    BLK_ONE   = BLOCK_BITS'(1);
    localparam logic [FIFO_DEPTH_LOG2:0] FIFO_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0] CNT_ONE   = (FIFO_DEPTH_LOG2 + 1)'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = FIFO_DEPTH_LOG2'(1);

    typedef struct packed {
        logic [BLOCK_BITS-1:0] addr;
        logic                  first;
        logic                  last;
        logic                  err;
        logic [NUM_L4-1:0]     pattern;
    } entry_t;

    // ------------------------------------------------------------------
    // Scheduler state
    // ------------------------------------------------------------------
    logic [1:0]            state, state_n;
    logic [BLOCK_BITS-1:0] next_blk, next_blk_n;
    logic [BLOCK_BITS-1:0] remaining, remaining_n;
    logic [NUM_L4-1:0]     pattern, pattern_n;
    logic                  first_pend, first_pend_n;
    logic                  start_evt;
    logic                  set_ovf;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    entry_t                       mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]     count;
    logic                         fifo_full;
    logic                         pop;
    logic                         can_push;
    logic                         push_req;
    entry_t                       push_entry;
    entry_t                       head;

    // ------------------------------------------------------------------
    // Window arithmetic, all modulo 2^BLOCK_BITS
    // ------------------------------------------------------------------
    logic [7:0]            len_eff;
    logic [BLOCK_BITS-1:0] len_b;
    logic [BLOCK_BITS-1:0] win_start;
    logic [BLOCK_BITS-1:0] win_end;

    // Working values for the ACTIVE-state update
    logic                  blk_ready;
    logic [BLOCK_BITS-1:0] lag;
    logic [BLOCK_BITS-1:0] nb_post;
    logic [BLOCK_BITS-1:0] rem_post;
    logic [BLOCK_BITS-1:0] rem_ext;
    logic [BLOCK_BITS-1:0] cand;
    logic                  is_last;

    assign len_eff   = (readout_len_i == 8'd0) ? 8'd1 : readout_len_i;
    assign len_b     = BLOCK_BITS'(len_eff);
    assign win_start = wr_block_i - BLOCK_BITS'(T1_offset_i);
    assign win_end   = win_start + len_b;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts
    // a push when the head is being acknowledged.
    assign fifo_full = (count == FIFO_FULL);
    assign pop       = (count != '0) && blk_ack_i;
    assign can_push  = !fifo_full || pop;

    // Next-state and push decision for the event scheduler
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n      = state;
        next_blk_n   = next_blk;
        remaining_n  = remaining;
        pattern_n    = pattern;
        first_pend_n = first_pend;
        start_evt    = 1'b0;
        set_ovf      = 1'b0;
        push_req     = 1'b0;
        push_entry   = '0;
        blk_ready    = 1'b0;
        lag          = wr_block_i - next_blk;
        nb_post      = next_blk;
        rem_post     = remaining;
        rem_ext      = remaining;
        cand         = '0;
        is_last      = 1'b0;

        case (state)
            ST_IDLE: begin
                // A T1 without a new L4 flag is not an event and is dropped.
                if (T1_i && (|l4_new_i)) begin
                    next_blk_n   = win_start;
                    remaining_n  = len_b;
                    pattern_n    = l4_matched_i;
                    first_pend_n = 1'b1;
                    start_evt    = 1'b1;
                    state_n      = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                if ((remaining != '0) && (lag >= MAX_LAG_B)) begin
                    // The writer has lapped the pending block: stop the
                    // event and emit an error terminator instead.
                    set_ovf     = 1'b1;
                    remaining_n = '0;
                    state_n     = ST_ABORT;
                end else begin
                    // Only blocks the writer has moved past are complete.
                    blk_ready = (remaining != '0) && can_push &&
                                (next_blk != wr_block_i);

                    nb_post  = blk_ready ? (next_blk + BLK_ONE) : next_blk;
                    rem_post = blk_ready ? (remaining - BLK_ONE) : remaining;
                    rem_ext  = rem_post;

                    // Any T1 seen while active widens the current window
                    // and joins its pattern instead of opening a new event.
                    if (T1_i) begin
                        pattern_n = pattern | l4_matched_i;
                        cand      = win_end - nb_post;
                        if (cand > rem_post) begin
                            rem_ext = cand;
                        end
                    end

                    next_blk_n  = nb_post;
                    remaining_n = rem_ext;

                    // The last flag is decided after the extension. A
                    // trigger that arrives with the final push keeps the
                    // event open, so the event still gets a single last.
                    is_last = (rem_ext == '0);

                    if (blk_ready) begin
                        push_req           = 1'b1;
                        push_entry.addr    = next_blk;
                        push_entry.first   = first_pend;
                        push_entry.last    = is_last;
                        push_entry.err     = 1'b0;
                        push_entry.pattern = is_last ? pattern_n : '0;
                        first_pend_n       = 1'b0;
                    end

                    if (rem_ext == '0) begin
                        state_n = ST_IDLE;
                    end
                end
            end

            ST_ABORT: begin
                // Triggers are ignored until the terminator has been queued.
                if (can_push) begin
                    push_req           = 1'b1;
                    push_entry.addr    = next_blk;
                    push_entry.first   = first_pend;
                    push_entry.last    = 1'b1;
                    push_entry.err     = 1'b1;
                    push_entry.pattern = pattern;
                    first_pend_n       = 1'b0;
                    state_n            = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Scheduler registers
    // NOTE: clocked state is assigned with <= so that all registers update from the same pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            next_blk   <= '0;
            remaining  <= '0;
            pattern    <= '0;
            first_pend <= 1'b0;
        end else begin
            state      <= state_n;
            next_blk   <= next_blk_n;
            remaining  <= remaining_n;
            pattern    <= pattern_n;
            first_pend <= first_pend_n;
        end
    end

    // Event counter and sticky lag-overflow flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            event_count_o <= '0;
            overflow_o    <= 1'b0;
        end else begin
            if (start_evt) begin
                event_count_o <= event_count_o + 16'd1;
            end
            if (set_ovf) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_req) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_req, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write port
    // NOTE: the storage array has no reset; an empty count already marks every slot invalid, and outputs are gated below.
    always_ff @(posedge clk_i) begin
        if (push_req) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Head of the FIFO, forced to zero while empty
    assign head          = mem[rd_ptr];
    assign blk_valid_o   = (count != '0);
    assign blk_addr_o    = blk_valid_o ? head.addr    : '0;
    assign blk_first_o   = blk_valid_o & head.first;
    assign blk_last_o    = blk_valid_o & head.last;
    assign blk_err_o     = blk_valid_o & head.err;
    assign blk_pattern_o = blk_valid_o ? head.pattern : '0;
    assign busy_o        = (state != ST_IDLE) || blk_valid_o;

endmodule
